// File: rtl/tpu_gemm_core.sv
// tpu_gemm_core: SA_DIM x SA_DIM output-stationary int8 systolic GEMM engine.
// Computes C[MxN] = A[MxK] * B[KxN], one SA_DIM x SA_DIM output tile at a time
// (nt outer, mt inner), with operand skew, ragged-edge masking and row write-back.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, K, M, N    start request and problem dimensions (sampled in IDLE)
//   busy, done           activity flag, one-cycle completion pulse
//   A_index/A_data_out   A buffer read port (one-cycle read latency)
//   B_index/B_data_out   B buffer read port (one-cycle read latency)
//   C_wr_en/C_index/C_data_in  C buffer write port, one output row per write
//   input_offset         signed offset added to A bytes (INPUT_OFFSET_EN only)
//
// Optional feature macro: INPUT_OFFSET_EN.
// SA_DIM must be at least 2.
module tpu_gemm_core #(
    parameter int unsigned SA_DIM    = 4,
    parameter int unsigned ACC_BITS  = 32,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [7:0]                 K,
    input  logic [7:0]                 M,
    input  logic [7:0]                 N,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_BITS-1:0]       A_index,
    input  logic [8*SA_DIM-1:0]        A_data_out,
    output logic [ADDR_BITS-1:0]       B_index,
    input  logic [8*SA_DIM-1:0]        B_data_out,
    output logic                       C_wr_en,
    output logic [ADDR_BITS-1:0]       C_index,
    output logic [ACC_BITS*SA_DIM-1:0] C_data_in
`ifdef INPUT_OFFSET_EN
    ,
    input  logic [8:0]                 input_offset
`endif
);

`ifdef INPUT_OFFSET_EN
    localparam int unsigned AW = 10;
`else
    localparam int unsigned AW = 8;
`endif
    localparam int unsigned PW         = AW + 8;
    localparam int unsigned RW         = $clog2(SA_DIM);
    localparam logic [7:0]  DRAIN_LAST = 8'(3 * SA_DIM - 3);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    k_q, k_d, cnt_q, cnt_d, mt_q, mt_d, nt_q, nt_d;
    logic [7:0]    K_q, K_d, M_q, M_d, N_q, N_d, mtn_q, mtn_d, ntn_q, ntn_d;
    logic [RW-1:0] r_q, r_d;
    logic          feed_v_q;
    logic          clr_acc;
`ifdef INPUT_OFFSET_EN
    logic signed [8:0] off_q;
`endif

    logic signed [AW-1:0]       a_in    [SA_DIM];
    logic signed [7:0]          b_in    [SA_DIM];
    logic signed [AW-1:0]       a_edge  [SA_DIM];
    logic signed [7:0]          b_edge  [SA_DIM];
    logic signed [AW-1:0]       a_dly_q [SA_DIM][SA_DIM-1];
    logic signed [7:0]          b_dly_q [SA_DIM][SA_DIM-1];
    logic signed [AW-1:0]       a_pe_q  [SA_DIM][SA_DIM];
    logic signed [7:0]          b_pe_q  [SA_DIM][SA_DIM];
    logic signed [ACC_BITS-1:0] acc_q   [SA_DIM][SA_DIM];

    // ---------------- Tiling FSM ----------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        mt_d    = mt_q;
        nt_d    = nt_q;
        r_d     = r_q;
        K_d     = K_q;
        M_d     = M_q;
        N_d     = N_q;
        mtn_d   = mtn_q;
        ntn_d   = ntn_q;
        unique case (state_q)
            S_IDLE: if (in_valid) begin
                K_d   = K;
                M_d   = M;
                N_d   = N;
                mtn_d = 8'((16'(M) + 16'(SA_DIM - 1)) / 16'(SA_DIM));
                ntn_d = 8'((16'(N) + 16'(SA_DIM - 1)) / 16'(SA_DIM));
                mt_d  = '0;
                nt_d  = '0;
                k_d   = '0;
                state_d = (K == 8'd0 || M == 8'd0 || N == 8'd0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                k_d = k_q + 8'd1;
                if (k_q == K_q - 8'd1) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_WRITE;
                    r_d     = '0;
                end
            end
            S_WRITE: begin
                r_d = r_q + RW'(1);
                if (r_q == RW'(SA_DIM - 1)) begin
                    k_d     = '0;
                    state_d = S_FEED;
                    if (mt_q == mtn_q - 8'd1) begin
                        mt_d = '0;
                        if (nt_q == ntn_q - 8'd1) state_d = S_DONE;
                        else                      nt_d    = nt_q + 8'd1;
                    end else begin
                        mt_d = mt_q + 8'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign clr_acc = (state_d == S_FEED) && (state_q != S_FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            mt_q     <= '0;
            nt_q     <= '0;
            r_q      <= '0;
            K_q      <= '0;
            M_q      <= '0;
            N_q      <= '0;
            mtn_q    <= '0;
            ntn_q    <= '0;
            feed_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            mt_q     <= mt_d;
            nt_q     <= nt_d;
            r_q      <= r_d;
            K_q      <= K_d;
            M_q      <= M_d;
            N_q      <= N_d;
            mtn_q    <= mtn_d;
            ntn_q    <= ntn_d;
            // Read data returns one cycle after the FEED address.
            feed_v_q <= (state_q == S_FEED);
        end
    end

`ifdef INPUT_OFFSET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           off_q <= '0;
        else if (state_q == S_IDLE && in_valid) off_q <= signed'(input_offset);
    end
`endif

    // ---------------- Operand masking and skew ----------------
    always_comb begin
        for (int unsigned i = 0; i < SA_DIM; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
            if (feed_v_q && (32'(mt_q) * SA_DIM + i < 32'(M_q))) begin
`ifdef INPUT_OFFSET_EN
                a_in[i] = AW'(signed'(A_data_out[8*i +: 8])) + AW'(off_q);
`else
                a_in[i] = signed'(A_data_out[8*i +: 8]);
`endif
            end
            if (feed_v_q && (32'(nt_q) * SA_DIM + i < 32'(N_q)))
                b_in[i] = signed'(B_data_out[8*i +: 8]);
        end
    end

    // Row/column i is taken from stage i-1 of its delay line, i.e. delayed i cycles.
    always_comb begin
        a_edge[0] = a_in[0];
        b_edge[0] = b_in[0];
        for (int unsigned i = 1; i < SA_DIM; i++) begin
            a_edge[i] = a_dly_q[i][i-1];
            b_edge[i] = b_dly_q[i][i-1];
        end
    end

    // ---------------- Skew registers and PE array ----------------
    // Idle cycles carry zero operands, so every PE accumulates each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SA_DIM; i++) begin
                for (int unsigned d = 0; d < SA_DIM - 1; d++) begin
                    a_dly_q[i][d] <= '0;
                    b_dly_q[i][d] <= '0;
                end
                for (int unsigned j = 0; j < SA_DIM; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < SA_DIM; i++) begin
                a_dly_q[i][0] <= a_in[i];
                b_dly_q[i][0] <= b_in[i];
                for (int unsigned d = 1; d < SA_DIM - 1; d++) begin
                    a_dly_q[i][d] <= a_dly_q[i][d-1];
                    b_dly_q[i][d] <= b_dly_q[i][d-1];
                end
                a_pe_q[i][0] <= a_edge[i];
                b_pe_q[0][i] <= b_edge[i];
                for (int unsigned j = 1; j < SA_DIM; j++) begin
                    a_pe_q[i][j] <= a_pe_q[i][j-1];
                    b_pe_q[j][i] <= b_pe_q[j-1][i];
                end
                for (int unsigned j = 0; j < SA_DIM; j++) begin
                    acc_q[i][j] <= clr_acc ? '0 :
                        acc_q[i][j] + ACC_BITS'(PW'(a_pe_q[i][j] * b_pe_q[i][j]));
                end
            end
        end
    end

    // ---------------- Outputs ----------------
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        A_index   = '0;
        B_index   = '0;
        C_index   = '0;
        C_wr_en   = 1'b0;
        C_data_in = '0;
        if (state_q == S_FEED) begin
            A_index = ADDR_BITS'(32'(mt_q) * 32'(K_q) + 32'(k_q));
            B_index = ADDR_BITS'(32'(nt_q) * 32'(K_q) + 32'(k_q));
        end
        if (state_q == S_WRITE) begin
            C_index = ADDR_BITS'(32'(nt_q) * 32'(M_q) + 32'(mt_q) * SA_DIM + 32'(r_q));
            C_wr_en = (32'(mt_q) * SA_DIM + 32'(r_q)) < 32'(M_q);
            for (int unsigned j = 0; j < SA_DIM; j++)
                C_data_in[ACC_BITS*j +: ACC_BITS] = acc_q[r_q][j];
        end
    end

endmodule

// File: tb/tb_tpu_gemm_core.sv
module tb_tpu_gemm_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   K, M, N;
    logic         busy, done;
    logic [15:0]  A_index, B_index, C_index;
    logic [31:0]  A_data_out, B_data_out;
    logic         C_wr_en;
    logic [127:0] C_data_in;
    logic [8:0]   input_offset;

    always #5 clk = ~clk;

    tpu_gemm_core #(.SA_DIM(4), .ACC_BITS(32), .ADDR_BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .K          (K),
        .M          (M),
        .N          (N),
        .busy       (busy),
        .done       (done),
        .A_index    (A_index),
        .A_data_out (A_data_out),
        .B_index    (B_index),
        .B_data_out (B_data_out),
        .C_wr_en    (C_wr_en),
        .C_index    (C_index),
        .C_data_in  (C_data_in)
`ifdef INPUT_OFFSET_EN
        ,
        .input_offset (input_offset)
`endif
    );

    logic [31:0]  amem [256];
    logic [31:0]  bmem [256];
    logic [127:0] cmem [256];
    int           wr_count;
    int           gA [8][8];
    int           gB [8][8];
    int           passed = 0;
    int           failed = 0;
    int           total  = 0;

    // Buffer models: one-cycle read latency, C writes captured on the clock edge.
    always @(posedge clk) begin
        A_data_out <= amem[A_index[7:0]];
        B_data_out <= bmem[B_index[7:0]];
    end

    always @(posedge clk) begin
        if (C_wr_en) begin
            cmem[C_index[7:0]] = C_data_in;
            wr_count = wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pack the golden matrices into buffer words; lanes outside M/N hold junk.
    task automatic load(input int m, input int n, input int k);
        logic [31:0] w;
        int row, col;
        for (int t = 0; t < 256; t++) begin
            amem[t] = '0;
            bmem[t] = '0;
            cmem[t] = {4{32'hDEADBEEF}};
        end
        wr_count = 0;
        for (int mt = 0; mt < (m + 3) / 4; mt++)
            for (int kk = 0; kk < k; kk++) begin
                w = '0;
                for (int i = 0; i < 4; i++) begin
                    row = mt * 4 + i;
                    w[8*i +: 8] = (row < m) ? 8'(gA[row][kk]) : 8'hA5;
                end
                amem[mt * k + kk] = w;
            end
        for (int nt = 0; nt < (n + 3) / 4; nt++)
            for (int kk = 0; kk < k; kk++) begin
                w = '0;
                for (int j = 0; j < 4; j++) begin
                    col = nt * 4 + j;
                    w[8*j +: 8] = (col < n) ? 8'(gB[kk][col]) : 8'h5A;
                end
                bmem[nt * k + kk] = w;
            end
    endtask

    function automatic logic [127:0] exp_row(input int nt, input int row,
                                             input int m, input int n, input int k);
        logic [127:0] w;
        int s, col;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            col = nt * 4 + j;
            s = 0;
            if (col < n && row < m)
                for (int kk = 0; kk < k; kk++) s += gA[row][kk] * gB[kk][col];
            w[32*j +: 32] = s;
        end
        return w;
    endfunction

    task automatic start(input int m, input int n, input int k);
        @(negedge clk);
        M = 8'(m);
        N = 8'(n);
        K = 8'(k);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input int m, input int n, input int k);
        int c;
        start(m, n, k);
        chk({tag, "_busy_rise"}, busy, 1'b1);
        c = 0;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, done, 1'b0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_writes"}, wr_count, ((n + 3) / 4) * m);
    endtask

    task automatic check_golden(input string tag, input int m, input int n, input int k);
        for (int nt = 0; nt < (n + 3) / 4; nt++)
            for (int row = 0; row < m; row++)
                chk($sformatf("%s_C%0d", tag, nt * m + row), cmem[nt * m + row],
                    exp_row(nt, row, m, n, k));
        chk({tag, "_no_extra_write"}, cmem[((n + 3) / 4) * m], {4{32'hDEADBEEF}});
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        in_valid = 1'b0;
        K = '0;
        M = '0;
        N = '0;
        input_offset = '0;
        for (int t = 0; t < 256; t++) begin
            amem[t] = '0;
            bmem[t] = '0;
        end
        wr_count = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_en", C_wr_en, 1'b0);
        chk("rst_A_index", A_index, 16'd0);
        chk("rst_B_index", B_index, 16'd0);
        chk("rst_C_index", C_index, 16'd0);
        chk("rst_C_data", C_data_in, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity A: C rows equal B rows
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                gA[i][j] = (i == j) ? 1 : 0;
                gB[i][j] = 4 * i + j + 1;
            end
        load(4, 4, 4);
        run("ident", 4, 4, 4);
        check_golden("ident", 4, 4, 4);
        chk("ident_row2_hand", cmem[2], {32'd12, 32'd11, 32'd10, 32'd9});

        // Extreme operands
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                gA[i][j] = 127;
                gB[i][j] = 127;
            end
        load(4, 4, 4);
        run("maxpos", 4, 4, 4);
        check_golden("maxpos", 4, 4, 4);
        chk("maxpos_hand", cmem[3][127:96], 32'd64516);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) gA[i][j] = -128;
        load(4, 4, 4);
        run("maxneg", 4, 4, 4);
        check_golden("maxneg", 4, 4, 4);
        chk("maxneg_hand", cmem[1][63:32], 32'hFFFF0200);

        // Ragged edges: M=5, N=6, K=3 random
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                gA[i][j] = int'($urandom_range(255, 0)) - 128;
                gB[i][j] = int'($urandom_range(255, 0)) - 128;
            end
        load(5, 6, 3);
        run("ragged", 5, 6, 3);
        check_golden("ragged", 5, 6, 3);
        chk("ragged_col6_zero", cmem[7][95:64], 32'd0);

        // Zero-dimension fast path
        load(4, 4, 0);
        start(4, 4, 0);
        chk("k0_busy", busy, 1'b1);
        chk("k0_done", done, 1'b1);
        chk("k0_A_index", A_index, 16'd0);
        @(negedge clk);
        chk("k0_busy_fall", busy, 1'b0);
        chk("k0_done_end", done, 1'b0);
        chk("k0_writes", wr_count, 0);

        // Abort with reset during FEED of the second tile
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) gA[i][j] = int'($urandom_range(255, 0)) - 128;
        load(8, 4, 4);
        start(8, 4, 4);
        c = 0;
        while (A_index !== 16'd4 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("abort_tile2_feed", A_index, 16'd4);
        chk("abort_tile1_writes", wr_count, 4);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_wr_en", C_wr_en, 1'b0);
        chk("abort_A_index", A_index, 16'd0);
        chk("abort_C_data", C_data_in, 128'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_more_writes", wr_count, 4);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) gA[i][j] = (i == j) ? 1 : 0;
        load(4, 4, 4);
        run("restart", 4, 4, 4);
        check_golden("restart", 4, 4, 4);

`ifdef INPUT_OFFSET_EN
        // Offset cancels A=-128 exactly; then doubles it
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                gA[i][j] = -128;
                gB[i][j] = 1;
            end
        load(4, 4, 4);
        input_offset = 9'd128;
        run("off_p128", 4, 4, 4);
        for (int r = 0; r < 4; r++) chk($sformatf("off_p128_C%0d", r), cmem[r], 128'd0);
        load(4, 4, 4);
        input_offset = 9'h180;
        run("off_m128", 4, 4, 4);
        for (int r = 0; r < 4; r++)
            chk($sformatf("off_m128_C%0d", r), cmem[r], {4{32'hFFFFFC00}});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
